// File: rtl/fetch_decode_queue_if.sv
// Fetch-to-decode handshake bundle: fetch push side, decode pop side and decoded head fields.
interface fetch_decode_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [63:0]      in_PC;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic [63:0]      out_PC;
  logic [5:0]       opcode;
  logic [4:0]       rt;
  logic [4:0]       ra;
  logic [4:0]       rb;
  logic [9:0]       xo;
  logic [63:0]      imm_sext;
  logic [63:0]      ds_sext;
  logic [CNT_W-1:0] count;

  // Queue side
  modport slave (
    input  in_valid, in_instr, in_PC, flush, out_ready,
    output in_ready, out_valid, out_instr, out_PC, opcode, rt, ra, rb, xo,
           imm_sext, ds_sext, count
  );

  // Fetch/decode environment side
  modport master (
    output in_valid, in_instr, in_PC, flush, out_ready,
    input  in_ready, out_valid, out_instr, out_PC, opcode, rt, ra, rb, xo,
           imm_sext, ds_sext, count
  );
endinterface

// File: rtl/fetch_decode_queue.sv
// Circular instruction queue between fetch and decode, with combinational decode of the head entry.
// Flush discards everything queued plus the instruction offered in the same cycle.
module fetch_decode_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  fetch_decode_queue_if.slave   q
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;
  logic             push_c;
  logic             pop_c;
  entry_t           head_c;

  assign q.in_ready  = (count_q < CNT_W'(DEPTH));
  assign q.out_valid = (count_q != '0);
  assign q.count     = count_q;

  assign push_c = q.in_valid  && q.in_ready  && !q.flush;
  assign pop_c  = q.out_valid && q.out_ready && !q.flush;

  // Pointer/occupancy next state; power-of-two depth lets pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage is never reset; occupancy gating hides stale contents
  always_ff @(posedge clk) begin
    if (push_c) mem_q[wr_ptr_q] <= '{instr: q.in_instr, pc: q.in_PC};
  end

  always_comb begin
    head_c = '0;
    if (q.out_valid) head_c = mem_q[rd_ptr_q];
  end

  assign q.out_instr = head_c.instr;
  assign q.out_PC    = head_c.pc;
  assign q.opcode    = head_c.instr[31:26];
  assign q.rt        = head_c.instr[25:21];
  assign q.ra        = head_c.instr[20:16];
  assign q.rb        = head_c.instr[15:11];
  assign q.xo        = head_c.instr[10:1];
  assign q.imm_sext  = {{48{head_c.instr[15]}}, head_c.instr[15:0]};
  assign q.ds_sext   = {{48{head_c.instr[15]}}, head_c.instr[15:2], 2'b00};

endmodule
